// File: rtl/mult_err_pkg.sv
// rtl/mult_err_pkg.sv - shared widths and FSM state type for the multiplier error monitor
// Ports: none (package). Provides N_DEFAULT, width helpers and state_t.
package mult_err_pkg;

  localparam int N_DEFAULT = 8;

  // Product width of two N-bit signed operands.
  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  // Difference / abs-difference / pair-count width (one guard bit over a product).
  function automatic int err_w(input int n);
    return 2 * n + 1;
  endfunction

  // Accumulated error width: 2^(2N) pairs times a (2N+1)-bit magnitude.
  function automatic int sum_w(input int n);
    return 4 * n + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/err_abs_diff.sv
// rtl/err_abs_diff.sv - combinational |approx - exact| and inequality flag
// Ports:
//   exact, approx : 2N-bit signed products of the same operand pair
//   abs_diff      : 2N+1-bit unsigned magnitude of approx - exact
//   neq           : high when the two products differ
module err_abs_diff
  import mult_err_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic signed [prod_w(N)-1:0] exact,
  input  logic signed [prod_w(N)-1:0] approx,
  output logic        [err_w(N)-1:0]  abs_diff,
  output logic                        neq
);

  localparam int PW = prod_w(N);
  localparam int EW = err_w(N);

  logic signed [EW-1:0] diff;

  // One extra bit keeps the difference of two full-range products exact,
  // and its magnitude (at most 2^(2N)-1) still fits unsigned in EW bits.
  always_comb begin
    diff     = $signed({approx[PW-1], approx}) - $signed({exact[PW-1], exact});
    abs_diff = diff[EW-1] ? $unsigned(-diff) : $unsigned(diff);
    neq      = (approx != exact);
  end

endmodule

// File: rtl/mult_err_monitor.sv
// rtl/mult_err_monitor.sv - exhaustive operand sweep and error statistics for an approximate multiplier
// Ports:
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_start, i_stall         : begin sweep (IDLE/DONE only), freeze operand issue
//   o_x, o_y, o_valid        : registered signed operand pair and its issue strobe
//   i_prod_exact/approx      : combinational products of o_x*o_y from the two multipliers
//   o_busy, o_done           : SWEEP/DRAIN indicator, DONE level
//   o_err_sum, o_err_cnt     : sum of |approx-exact|, number of differing pairs
//   o_max_err, o_max_exact   : largest |approx-exact|, largest signed exact product
//   o_count                  : number of pairs accumulated
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_stall,
  output logic signed [N-1:0]         o_x,
  output logic signed [N-1:0]         o_y,
  output logic                        o_valid,
  input  logic signed [prod_w(N)-1:0] i_prod_exact,
  input  logic signed [prod_w(N)-1:0] i_prod_approx,
  output logic                        o_busy,
  output logic                        o_done,
  output logic        [sum_w(N)-1:0]  o_err_sum,
  output logic        [err_w(N)-1:0]  o_err_cnt,
  output logic        [err_w(N)-1:0]  o_max_err,
  output logic signed [prod_w(N)-1:0] o_max_exact,
  output logic        [err_w(N)-1:0]  o_count
);

  localparam int PW = prod_w(N);
  localparam int EW = err_w(N);
  localparam int SW = sum_w(N);

  state_t state, state_nxt;

  logic [PW-1:0] idx;
  logic          drain_cnt;
  logic          last_pair;

  logic [EW-1:0] abs_now;
  logic          neq_now;

  logic                 s1_valid;
  logic [EW-1:0]        s1_abs;
  logic                 s1_neq;
  logic signed [PW-1:0] s1_exact;

  // x is the outer loop (high half of the index), y the inner loop.
  assign o_x = idx[PW-1:N];
  assign o_y = idx[N-1:0];

  assign last_pair = (idx == {PW{1'b1}});

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        o_busy = 1'b1;
        if (!i_stall && last_pair) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (drain_cnt) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) state_nxt = ST_SWEEP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  err_abs_diff #(.N(N)) u_abs (
    .exact    (i_prod_exact),
    .approx   (i_prod_approx),
    .abs_diff (abs_now),
    .neq      (neq_now)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx         <= '0;
      o_valid     <= 1'b0;
      drain_cnt   <= 1'b0;
      s1_valid    <= 1'b0;
      s1_abs      <= '0;
      s1_neq      <= 1'b0;
      s1_exact    <= '0;
      o_err_sum   <= '0;
      o_err_cnt   <= '0;
      o_max_err   <= '0;
      o_max_exact <= '0;
      o_count     <= '0;
    end else begin
      // Stage 1: capture the products only for a freshly issued pair.
      s1_valid <= o_valid;
      if (o_valid) begin
        s1_abs   <= abs_now;
        s1_neq   <= neq_now;
        s1_exact <= i_prod_exact;
      end

      // Stage 2: accumulate statistics.
      if (s1_valid) begin
        o_err_sum <= o_err_sum + {{(SW-EW){1'b0}}, s1_abs};
        o_err_cnt <= o_err_cnt + {{(EW-1){1'b0}}, s1_neq};
        o_count   <= o_count + EW'(1);
        if (s1_abs > o_max_err)     o_max_err   <= s1_abs;
        if (s1_exact > o_max_exact) o_max_exact <= s1_exact;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          // Pipeline is empty here, so clearing overrides nothing in flight.
          if (i_start) begin
            idx         <= '0;
            o_valid     <= 1'b1;
            s1_valid    <= 1'b0;
            o_err_sum   <= '0;
            o_err_cnt   <= '0;
            o_max_err   <= '0;
            o_max_exact <= '0;
            o_count     <= '0;
          end
        end
        ST_SWEEP: begin
          // A non-stalled edge retires the current index; after a stall the
          // held pair was already issued, so the next edge moves on.
          if (i_stall) begin
            o_valid <= 1'b0;
          end else if (last_pair) begin
            o_valid   <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            idx     <= idx + PW'(1);
            o_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_err_monitor.sv
// tb/tb_mult_err_monitor.sv - directed self-checking bench for mult_err_monitor (N=8 and N=4 instances)
// Ports: none (testbench top).
module tb_mult_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- N=8 instance ----------------
  logic               rst8, start8, stall8;
  logic signed [7:0]  x8, y8;
  logic               v8, busy8, done8;
  logic signed [15:0] ex8, ap8;
  logic [32:0]        sum8;
  logic [16:0]        cnt8, merr8, count8;
  logic signed [15:0] mex8;
  int                 mode8;

  assign ex8 = x8 * y8;
  assign ap8 = (mode8 == 1) ? ex8 + 16'sd1 : (mode8 == 2) ? 16'sd0 : ex8;

  mult_err_monitor #(.N(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_stall(stall8),
    .o_x(x8), .o_y(y8), .o_valid(v8),
    .i_prod_exact(ex8), .i_prod_approx(ap8),
    .o_busy(busy8), .o_done(done8),
    .o_err_sum(sum8), .o_err_cnt(cnt8), .o_max_err(merr8),
    .o_max_exact(mex8), .o_count(count8)
  );

  // ---------------- N=4 instance ----------------
  logic              rst4, start4, stall4;
  logic signed [3:0] x4, y4;
  logic              v4, busy4, done4;
  logic signed [7:0] ex4, ap4;
  logic [16:0]       sum4;
  logic [8:0]        cnt4, merr4, count4;
  logic signed [7:0] mex4;
  int                mode4;

  assign ex4 = x4 * y4;
  assign ap4 = (mode4 == 1) ? ex4 + 8'sd1 : (mode4 == 2) ? 8'sd0 : ex4;

  mult_err_monitor #(.N(4)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_start(start4), .i_stall(stall4),
    .o_x(x4), .o_y(y4), .o_valid(v4),
    .i_prod_exact(ex4), .i_prod_approx(ap4),
    .o_busy(busy4), .o_done(done4),
    .o_err_sum(sum4), .o_err_cnt(cnt4), .o_max_err(merr4),
    .o_max_exact(mex4), .o_count(count4)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start an N=4 sweep from a negedge; returns edges from acceptance to done
  // (or to the reset edge) and the number of stalls that landed in SWEEP.
  task automatic run4(input int pct, input int start_at, input int rst_at,
                      output int cyc, output int stalls);
    int adv;
    bit st;
    adv = 0;
    stalls = 0;
    cyc = 0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("n4_first_x", x4, 0);
    chk("n4_first_y", y4, 0);
    chk("n4_first_valid", v4, 1);
    chk("n4_first_busy", busy4, 1);
    chk("n4_first_done", done4, 0);
    chk("n4_first_count", count4, 0);
    while (cyc < 2000) begin
      st = (pct > 0) && ($urandom_range(99) < pct);
      stall4 = st;
      if (adv < 256) begin
        if (st) stalls++;
        else    adv++;
      end
      start4 = (cyc == start_at);
      rst4   = (cyc == rst_at);
      @(negedge clk);
      cyc++;
      if (rst4) break;
      if (done4) break;
    end
    stall4 = 1'b0;
    start4 = 1'b0;
  endtask

  initial begin
    int cyc;
    int stalls;

    rst8 = 1'b1; start8 = 1'b0; stall8 = 1'b0; mode8 = 0;
    rst4 = 1'b1; start4 = 1'b0; stall4 = 1'b0; mode4 = 0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);

    chk("rst_x", x8, 0);
    chk("rst_y", y8, 0);
    chk("rst_valid", v8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_err_sum", sum8, 0);
    chk("rst_err_cnt", cnt8, 0);
    chk("rst_max_err", merr8, 0);
    chk("rst_max_exact", mex8, 0);
    chk("rst_count", count8, 0);

    // Full N=8 sweep with matching multipliers.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    chk("n8_pair0_x", x8, 0);
    chk("n8_pair0_y", y8, 0);
    chk("n8_pair0_valid", v8, 1);
    chk("n8_busy", busy8, 1);
    while (!done8 && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1)     begin chk("n8_pair1_x", x8, 0);   chk("n8_pair1_y", y8, 1);    end
      if (cyc == 127)   begin chk("n8_pair127_x", x8, 0); chk("n8_pair127_y", y8, 127); end
      if (cyc == 128)   begin chk("n8_pair128_x", x8, 0); chk("n8_pair128_y", y8, -128); end
      if (cyc == 256)   begin chk("n8_pair256_x", x8, 1); chk("n8_pair256_y", y8, 0);   end
      if (cyc == 32768) begin
        chk("n8_pair32768_x", x8, -128);
        chk("n8_pair32768_y", y8, 0);
        chk("n8_pair32768_valid", v8, 1);
      end
    end
    chk("n8_latency", cyc, 65538);
    chk("n8_err_sum", sum8, 0);
    chk("n8_err_cnt", cnt8, 0);
    chk("n8_max_err", merr8, 0);
    chk("n8_count", count8, 65536);
    chk("n8_max_exact", mex8, 16384);
    chk("n8_busy_done", busy8, 0);

    // N=4: approx = exact + 1.
    mode4 = 1;
    run4(0, -1, -1, cyc, stalls);
    chk("p1_latency", cyc, 258);
    chk("p1_err_sum", sum4, 256);
    chk("p1_err_cnt", cnt4, 256);
    chk("p1_max_err", merr4, 1);
    chk("p1_max_exact", mex4, 64);
    chk("p1_count", count4, 256);

    // N=4: approx = 0 (started from DONE, so results must be cleared first).
    mode4 = 2;
    run4(0, -1, -1, cyc, stalls);
    chk("z_latency", cyc, 258);
    chk("z_err_sum", sum4, 4096);
    chk("z_err_cnt", cnt4, 225);
    chk("z_max_err", merr4, 64);
    chk("z_count", count4, 256);
    chk("z_max_exact", mex4, 64);

    // N=4: approx = exact + 1 with 30% random stall.
    mode4 = 1;
    run4(30, -1, -1, cyc, stalls);
    chk("st_latency", cyc, 258 + stalls);
    chk("st_err_sum", sum4, 256);
    chk("st_err_cnt", cnt4, 256);
    chk("st_max_err", merr4, 1);
    chk("st_count", count4, 256);

    // Start pulsed mid-sweep is ignored.
    mode4 = 0;
    run4(0, 100, -1, cyc, stalls);
    chk("ms_latency", cyc, 258);
    chk("ms_count", count4, 256);
    chk("ms_err_sum", sum4, 0);

    // Reset mid-sweep clears everything on the next edge.
    run4(0, -1, 100, cyc, stalls);
    chk("mr_x", x4, 0);
    chk("mr_y", y4, 0);
    chk("mr_valid", v4, 0);
    chk("mr_busy", busy4, 0);
    chk("mr_done", done4, 0);
    chk("mr_count", count4, 0);
    chk("mr_err_sum", sum4, 0);
    chk("mr_max_exact", mex4, 0);
    rst4 = 1'b0;

    // Fresh run after the reset is complete and correct.
    run4(0, -1, -1, cyc, stalls);
    chk("ar_latency", cyc, 258);
    chk("ar_count", count4, 256);
    chk("ar_err_cnt", cnt4, 0);
    chk("ar_max_exact", mex4, 64);
    chk("ar_done", done4, 1);

    // Reset wins over start in the same cycle.
    rst4 = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    start4 = 1'b0;
    chk("pri_busy", busy4, 0);
    chk("pri_valid", v4, 0);
    chk("pri_done", done4, 0);
    chk("pri_count", count4, 0);
    @(negedge clk);
    chk("pri_idle_busy", busy4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
